// File: rtl/stupidrv_dma_pkg.sv
// Shared types and constants for the stupidrv word-copy DMA engine.
package stupidrv_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FILL,
        ST_DONE
    } dma_state_t;

    localparam logic [3:0]  WSTRB_WRITE = 4'hF;
    localparam logic [3:0]  WSTRB_READ  = 4'h0;
    localparam logic [31:0] WORD_BYTES  = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/stupidrv_dma.sv
// Word-copy DMA initiator on the stupidrv dmem bus; bus cycles granted externally.
// Optional fill mode (pattern write, no reads) enabled by defining STUPIDRV_DMA_FILL_EN.
module stupidrv_dma
    import stupidrv_dma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 cfg_start,
    input  logic [31:0]          cfg_src,
    input  logic [31:0]          cfg_dst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 cfg_fill,
    input  logic [31:0]          cfg_pattern,
    input  logic                 dma_grant,
    output logic                 busy,
    output logic                 done,
    output logic                 dmem_valid,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_wstrb,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata
);

    dma_state_t           state;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] count_q;
    logic [31:0]          buf_q;
    logic                 fresh_q;

`ifdef STUPIDRV_DMA_FILL_EN
    logic [31:0]          pattern_q;
`else
    logic                 unused_fill_cfg;
    assign unused_fill_cfg = ^{cfg_fill, cfg_pattern};
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            fresh_q <= 1'b0;
`ifdef STUPIDRV_DMA_FILL_EN
            pattern_q <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        src_q   <= word_align(cfg_src);
                        dst_q   <= word_align(cfg_dst);
                        count_q <= cfg_len;
                        fresh_q <= 1'b0;
`ifdef STUPIDRV_DMA_FILL_EN
                        pattern_q <= cfg_pattern;
`endif
                        if (cfg_len == '0)
                            state <= ST_DONE;
`ifdef STUPIDRV_DMA_FILL_EN
                        else if (cfg_fill)
                            state <= ST_FILL;
`endif
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (dma_grant) begin
                        src_q   <= src_q + WORD_BYTES;
                        fresh_q <= 1'b1;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // rdata is only on the bus for one cycle; keep it for grant stalls
                    if (fresh_q) begin
                        buf_q   <= dmem_rdata;
                        fresh_q <= 1'b0;
                    end
                    if (dma_grant) begin
                        dst_q   <= dst_q + WORD_BYTES;
                        count_q <= count_q - LEN_WIDTH'(1);
                        state   <= (count_q == LEN_WIDTH'(1)) ? ST_DONE : ST_READ;
                    end
                end
`ifdef STUPIDRV_DMA_FILL_EN
                ST_FILL: begin
                    if (dma_grant) begin
                        dst_q   <= dst_q + WORD_BYTES;
                        count_q <= count_q - LEN_WIDTH'(1);
                        if (count_q == LEN_WIDTH'(1))
                            state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_valid = 1'b0;
        dmem_addr  = '0;
        dmem_wstrb = WSTRB_READ;
        dmem_wdata = '0;
        case (state)
            ST_READ: begin
                if (dma_grant) begin
                    dmem_valid = 1'b1;
                    dmem_addr  = src_q;
                end
            end
            ST_WRITE: begin
                if (dma_grant) begin
                    dmem_valid = 1'b1;
                    dmem_addr  = dst_q;
                    dmem_wstrb = WSTRB_WRITE;
                    dmem_wdata = fresh_q ? dmem_rdata : buf_q;
                end
            end
`ifdef STUPIDRV_DMA_FILL_EN
            ST_FILL: begin
                if (dma_grant) begin
                    dmem_valid = 1'b1;
                    dmem_addr  = dst_q;
                    dmem_wstrb = WSTRB_WRITE;
                    dmem_wdata = pattern_q;
                end
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_stupidrv_dma.sv
// Directed bench for stupidrv_dma with a 1024-word memory model and grant driver.
`timescale 1ns/1ps
module tb_stupidrv_dma;
    import stupidrv_dma_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic        cfg_start;
    logic [31:0] cfg_src;
    logic [31:0] cfg_dst;
    logic [15:0] cfg_len;
    logic        cfg_fill;
    logic [31:0] cfg_pattern;
    logic        dma_grant;
    logic        busy;
    logic        done;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    stupidrv_dma #(.LEN_WIDTH(16)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cfg_start   (cfg_start),
        .cfg_src     (cfg_src),
        .cfg_dst     (cfg_dst),
        .cfg_len     (cfg_len),
        .cfg_fill    (cfg_fill),
        .cfg_pattern (cfg_pattern),
        .dma_grant   (dma_grant),
        .busy        (busy),
        .done        (done),
        .dmem_valid  (dmem_valid),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0001_0101) ^ 32'hC0DE_0000;
    endfunction

    // memory: rdata registered one cycle after any valid request
    logic [31:0] mem [0:1023];
    logic [31:0] rdata_q;
    logic        load_en = 1'b0;

    always @(posedge clock) begin
        if (load_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            rdata_q <= '0;
        end else if (dmem_valid) begin
            rdata_q <= mem[dmem_addr[11:2]];
            if (dmem_wstrb == 4'hF) mem[dmem_addr[11:2]] <= dmem_wdata;
        end
    end
    assign dmem_rdata = rdata_q;

    logic [31:0] exp_mem [0:1023];

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    endtask

    task automatic model_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                              input logic f, input logic [31:0] p);
        logic [31:0] sa;
        logic [31:0] da;
        logic        do_fill;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
`ifdef STUPIDRV_DMA_FILL_EN
        do_fill = f;
`else
        do_fill = f & 1'b0;
`endif
        for (int k = 0; k < n; k++) begin
            if (do_fill) exp_mem[da[11:2]] = p;
            else         exp_mem[da[11:2]] = exp_mem[sa[11:2]];
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    function automatic int mem_diffs();
        int nd = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) nd++;
        return nd;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        fill;
        logic [31:0] pattern;
        int          stall;
        int          restart_at;
        int          exp_cycles;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_first;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                                input logic f, input logic [31:0] p, input int st, input int ra,
                                input int cy, input int nr, input int nw, input logic [31:0] fw);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.fill = f; v.pattern = p;
        v.stall = st; v.restart_at = ra;
        v.exp_cycles = cy; v.exp_reads = nr; v.exp_writes = nw; v.exp_first = fw;
        return v;
    endfunction

    task automatic run_xfer(input vec_t v, output int cyc, output int nr, output int nw,
                            output int gap_valid, output int alt_err, output int busy_cyc,
                            output logic [31:0] first_wdata);
        int   gap_left;
        logic last_read;
        logic seen_req;
        logic first_w;
        gap_left = 0; last_read = 1'b0; seen_req = 1'b0; first_w = 1'b0;
        cyc = -1; nr = 0; nw = 0; gap_valid = 0; alt_err = 0; busy_cyc = 0; first_wdata = '0;
        cfg_src = v.src; cfg_dst = v.dst; cfg_len = v.len;
        cfg_fill = v.fill; cfg_pattern = v.pattern;
        dma_grant = 1'b1;
        cfg_start = 1'b1;
        @(posedge clock); #1;
        for (int c = 1; c <= 200; c++) begin
            if (c == v.restart_at) begin
                cfg_src = 32'h0; cfg_dst = 32'h300; cfg_len = 16'd2; cfg_fill = 1'b0;
                cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            dma_grant = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            @(negedge clock);
            if (busy) busy_cyc++;
            if (dmem_valid) begin
                if (!dma_grant) gap_valid++;
                if (dmem_wstrb == 4'hF) begin
                    if (!first_w) first_wdata = dmem_wdata;
                    first_w = 1'b1;
                    if (seen_req && !last_read && v.exp_reads != 0) alt_err++;
                    nw++;
                    last_read = 1'b0;
                end else begin
                    if (nr == 0) gap_left = v.stall;
                    if (seen_req && last_read) alt_err++;
                    nr++;
                    last_read = 1'b1;
                end
                seen_req = 1'b1;
            end
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clock); #1;
        end
        cfg_start = 1'b0;
        dma_grant = 1'b1;
    endtask

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, nr, nw, gv, ae, bc, done_seen;
        logic [31:0] fw;

        vecs[0] = mk(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 0, 0, 9, 4, 4, init_word(64));
        vecs[1] = mk(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 3, 0, 12, 4, 4, init_word(64));
        vecs[2] = mk(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 0, 3, 9, 4, 4, init_word(64));
        vecs[3] = mk(32'h103, 32'h202, 16'd2, 1'b0, 32'h0, 0, 0, 5, 2, 2, init_word(64));
        vecs[4] = mk(32'h100, 32'h104, 16'd3, 1'b0, 32'h0, 0, 0, 7, 3, 3, init_word(64));
        vecs[5] = mk(32'hFFFF_FFFC, 32'h280, 16'd2, 1'b0, 32'h0, 0, 0, 5, 2, 2, init_word(1023));
        vecs[6] = mk(32'h000, 32'h3F0, 16'd1, 1'b0, 32'h0, 0, 0, 3, 1, 1, init_word(0));
        vecs[7] = mk(32'h100, 32'h200, 16'd0, 1'b0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
`ifdef STUPIDRV_DMA_FILL_EN
        vecs[8] = mk(32'h100, 32'h300, 16'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 4, 0, 3, 32'hDEAD_BEEF);
`else
        vecs[8] = mk(32'h100, 32'h300, 16'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 7, 3, 3, init_word(64));
`endif

        resetn = 1'b0; cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        cfg_fill = 1'b0; cfg_pattern = '0; dma_grant = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset busy",  32'(busy), 32'h0);
        check("reset done",  32'(done), 32'h0);
        check("reset valid", 32'(dmem_valid), 32'h0);
        check("reset addr",  dmem_addr, 32'h0);
        check("reset wstrb", 32'(dmem_wstrb), 32'h0);
        check("reset wdata", dmem_wdata, 32'h0);
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            load_en = 1'b1;
            @(posedge clock); #1;
            load_en = 1'b0;
            model_reset();
            model_xfer(vecs[i].src, vecs[i].dst, int'(vecs[i].len), vecs[i].fill, vecs[i].pattern);
            run_xfer(vecs[i], cyc, nr, nw, gv, ae, bc, fw);
            check($sformatf("v%0d done_cycle", i), 32'(cyc), 32'(vecs[i].exp_cycles));
            check($sformatf("v%0d reads", i),      32'(nr),  32'(vecs[i].exp_reads));
            check($sformatf("v%0d writes", i),     32'(nw),  32'(vecs[i].exp_writes));
            check($sformatf("v%0d valid_no_grant", i), 32'(gv), 32'h0);
            check($sformatf("v%0d alternation", i), 32'(ae), 32'h0);
            check($sformatf("v%0d busy_cycles", i), 32'(bc), 32'(vecs[i].exp_cycles));
            check($sformatf("v%0d first_wdata", i), fw, vecs[i].exp_first);
            @(posedge clock); #1;
            check($sformatf("v%0d mem_diffs", i), 32'(mem_diffs()), 32'h0);
            check($sformatf("v%0d idle_after", i), 32'(busy), 32'h0);
        end

        // reset abort after the second write of a 4-word copy
        load_en = 1'b1;
        @(posedge clock); #1;
        load_en = 1'b0;
        model_reset();
        model_xfer(32'h100, 32'h200, 2, 1'b0, 32'h0);
        cfg_src = 32'h100; cfg_dst = 32'h200; cfg_len = 16'd4; cfg_fill = 1'b0;
        dma_grant = 1'b1; cfg_start = 1'b1;
        @(posedge clock); #1;
        cfg_start = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check("abort pre valid", 32'(dmem_valid), 32'h1);
        resetn = 1'b0;
        #1;
        check("abort busy",  32'(busy), 32'h0);
        check("abort done",  32'(done), 32'h0);
        check("abort valid", 32'(dmem_valid), 32'h0);
        check("abort addr",  dmem_addr, 32'h0);
        check("abort wstrb", 32'(dmem_wstrb), 32'h0);
        check("abort wdata", dmem_wdata, 32'h0);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (done || dmem_valid) done_seen++;
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (done || dmem_valid) done_seen++;
        end
        check("abort no_done_or_req", 32'(done_seen), 32'h0);
        check("abort mem_diffs", 32'(mem_diffs()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
